// File: rtl/krnl_vadd_sched_pkg.sv
// Shared kernel package for the vadd command scheduler: FSM states, width
// defaults and the chunk-size helper.
package krnl_vadd_sched_pkg;

  localparam int unsigned KRNL_ADDR_W      = 64;
  localparam int unsigned KRNL_LEN_W       = 32;
  localparam int unsigned KRNL_BURST_BYTES = 4096;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_A,
    ISSUE_B,
    ISSUE_C,
    DRAIN,
    DONE
  } sched_state_e;

  // Operands are passed at 64 bits so any LEN_W up to 64 can use the helper.
  function automatic logic [63:0] min_chunk(input logic [63:0] remaining,
                                            input logic [63:0] burst);
    return (remaining < burst) ? remaining : burst;
  endfunction

endpackage

// File: rtl/krnl_vadd_sched_credit.sv
// Saturating up/down credit counter that bounds the number of write chunks
// issued but not yet responded.
module vadd_credit_cnt #(
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic dec_i,
  output logic zero_o,
  output logic can_issue_o
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Simultaneous increment and decrement cancel; a decrement at zero is dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != MaxCnt)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

  // Looks at the next count so a registered valid can rise the cycle a credit frees.
  assign can_issue_o = (cnt_d < MaxCnt);

endmodule

// File: rtl/krnl_vadd_sched.sv
// vadd command scheduler: splits an ap_ctrl_hs job into burst chunks and
// issues A/B read commands and a C write command per chunk, credit-limited.
module krnl_vadd_sched
  import krnl_vadd_sched_pkg::*;
#(
  parameter int unsigned ADDR_W      = KRNL_ADDR_W,
  parameter int unsigned LEN_W       = KRNL_LEN_W,
  parameter int unsigned DATA_BYTES  = 64,
  parameter int unsigned BURST_BYTES = KRNL_BURST_BYTES,
  parameter int unsigned MAX_OUT     = 4
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic              ap_done,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  input  logic [LEN_W-1:0]  len_bytes,
  output logic              rd_cmd_valid,
  input  logic              rd_cmd_ready,
  output logic [ADDR_W-1:0] rd_cmd_addr,
  output logic [LEN_W-1:0]  rd_cmd_bytes,
  output logic              rd_cmd_sel,
  output logic              wr_cmd_valid,
  input  logic              wr_cmd_ready,
  output logic [ADDR_W-1:0] wr_cmd_addr,
  output logic [LEN_W-1:0]  wr_cmd_bytes,
  input  logic              wr_resp
);

  sched_state_e      state_q, state_d;
  logic [ADDR_W-1:0] cur_a_q, cur_a_d, cur_b_q, cur_b_d, cur_c_q, cur_c_d;
  logic [LEN_W-1:0]  rem_q, rem_d, chunk_q, chunk_d;
  logic [LEN_W-1:0]  len_floor;

  logic              idle_q, idle_d, done_q, done_d;
  logic              rd_valid_q, rd_valid_d, rd_sel_q, rd_sel_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [LEN_W-1:0]  rd_bytes_q, rd_bytes_d;
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [LEN_W-1:0]  wr_bytes_q, wr_bytes_d;

  logic rd_hs, wr_hs, cnt_zero, can_issue;

  assign rd_hs     = rd_valid_q && rd_cmd_ready;
  assign wr_hs     = wr_valid_q && wr_cmd_ready;
  assign len_floor = len_bytes & ~LEN_W'(DATA_BYTES - 1);

  vadd_credit_cnt #(
    .MAX_OUT(MAX_OUT)
  ) u_credit (
    .clk_i      (ap_clk),
    .rst_ni     (ap_rst_n),
    .inc_i      (wr_hs),
    .dec_i      (wr_resp),
    .zero_o     (cnt_zero),
    .can_issue_o(can_issue)
  );

  // A zero-length job passes through DRAIN (credits are already zero) so its
  // ap_done lands on the same cycle-2 slot as every other DRAIN exit.
  always_comb begin
    state_d = state_q;
    cur_a_d = cur_a_q;
    cur_b_d = cur_b_q;
    cur_c_d = cur_c_q;
    rem_d   = rem_q;
    chunk_d = chunk_q;
    unique case (state_q)
      IDLE: begin
        if (ap_start) begin
          cur_a_d = base_a;
          cur_b_d = base_b;
          cur_c_d = base_c;
          rem_d   = len_floor;
          state_d = (len_floor == '0) ? DRAIN : ISSUE_A;
        end
      end
      ISSUE_A: if (rd_hs) state_d = ISSUE_B;
      ISSUE_B: if (rd_hs) state_d = ISSUE_C;
      ISSUE_C: begin
        if (wr_hs) begin
          cur_a_d = cur_a_q + ADDR_W'(chunk_q);
          cur_b_d = cur_b_q + ADDR_W'(chunk_q);
          cur_c_d = cur_c_q + ADDR_W'(chunk_q);
          rem_d   = rem_q - chunk_q;
          state_d = (rem_q == chunk_q) ? DRAIN : ISSUE_A;
        end
      end
      DRAIN:   if (cnt_zero) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if ((state_d == ISSUE_A) && (state_q != ISSUE_A)) begin
      chunk_d = LEN_W'(min_chunk(64'(rem_d), 64'(BURST_BYTES)));
    end
  end

  // Outputs are registered from next-state values so commands appear the
  // cycle the FSM enters the issuing state.
  always_comb begin
    idle_d     = (state_d == IDLE);
    done_d     = (state_d == DONE);
    rd_valid_d = ((state_d == ISSUE_A) && can_issue) || (state_d == ISSUE_B);
    rd_sel_d   = (state_d == ISSUE_B);
    rd_addr_d  = rd_addr_q;
    rd_bytes_d = rd_bytes_q;
    wr_valid_d = (state_d == ISSUE_C);
    wr_addr_d  = wr_addr_q;
    wr_bytes_d = wr_bytes_q;
    if (state_d == ISSUE_A) begin
      rd_addr_d  = cur_a_d;
      rd_bytes_d = chunk_d;
    end else if (state_d == ISSUE_B) begin
      rd_addr_d  = cur_b_d;
      rd_bytes_d = chunk_d;
    end
    if (state_d == ISSUE_C) begin
      wr_addr_d  = cur_c_d;
      wr_bytes_d = chunk_d;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= IDLE;
      cur_a_q    <= '0;
      cur_b_q    <= '0;
      cur_c_q    <= '0;
      rem_q      <= '0;
      chunk_q    <= '0;
      idle_q     <= 1'b1;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_addr_q  <= '0;
      rd_bytes_q <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_bytes_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_a_q    <= cur_a_d;
      cur_b_q    <= cur_b_d;
      cur_c_q    <= cur_c_d;
      rem_q      <= rem_d;
      chunk_q    <= chunk_d;
      idle_q     <= idle_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_sel_q   <= rd_sel_d;
      rd_addr_q  <= rd_addr_d;
      rd_bytes_q <= rd_bytes_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_bytes_q <= wr_bytes_d;
    end
  end

  assign ap_idle      = idle_q;
  assign ap_done      = done_q;
  assign ap_ready     = done_q;
  assign rd_cmd_valid = rd_valid_q;
  assign rd_cmd_sel   = rd_sel_q;
  assign rd_cmd_addr  = rd_addr_q;
  assign rd_cmd_bytes = rd_bytes_q;
  assign wr_cmd_valid = wr_valid_q;
  assign wr_cmd_addr  = wr_addr_q;
  assign wr_cmd_bytes = wr_bytes_q;

endmodule

// File: tb/tb_krnl_vadd_sched.sv
// Self-checking bench for krnl_vadd_sched: directed jobs plus randomized jobs,
// checked against a command list derived from base/length arithmetic.
module tb_krnl_vadd_sched;

  localparam int BURST = 4096;
  localparam int MAXO  = 4;

  typedef struct {
    bit          isWr;
    bit          sel;
    logic [63:0] addr;
    logic [31:0] bytes;
  } cmd_t;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        ap_start = 1'b0;
  logic        ap_idle, ap_ready, ap_done;
  logic [63:0] base_a = '0, base_b = '0, base_c = '0;
  logic [31:0] len_bytes = '0;
  logic        rd_cmd_valid, rd_cmd_sel, wr_cmd_valid;
  logic        rd_cmd_ready = 1'b1, wr_cmd_ready = 1'b1;
  logic [63:0] rd_cmd_addr, wr_cmd_addr;
  logic [31:0] rd_cmd_bytes, wr_cmd_bytes;
  logic        wr_resp = 1'b0;

  cmd_t expQ[$];
  int   respQ[$];
  int   assertCnt = 0;
  int   failCnt = 0;
  int   cyc = 0;
  int   wrCount = 0;
  int   modelOut = 0;
  int   lastRespCyc = 0;
  bit   autoResp = 1'b1;
  bit   randReady = 1'b0;
  bit   randResp = 1'b0;

  krnl_vadd_sched dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .ap_start    (ap_start),
    .ap_idle     (ap_idle),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .base_a      (base_a),
    .base_b      (base_b),
    .base_c      (base_c),
    .len_bytes   (len_bytes),
    .rd_cmd_valid(rd_cmd_valid),
    .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_addr (rd_cmd_addr),
    .rd_cmd_bytes(rd_cmd_bytes),
    .rd_cmd_sel  (rd_cmd_sel),
    .wr_cmd_valid(wr_cmd_valid),
    .wr_cmd_ready(wr_cmd_ready),
    .wr_cmd_addr (wr_cmd_addr),
    .wr_cmd_bytes(wr_cmd_bytes),
    .wr_resp     (wr_resp)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    assertCnt++;
    assert (obs === expv) else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic compareCmd(input bit isWr, input bit sel, input logic [63:0] addr,
                            input logic [31:0] bytes);
    cmd_t e;
    checkOutput("cmd_expected", 64'(expQ.size() > 0), 64'd1);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("cmd_kind", 64'(isWr), 64'(e.isWr));
      checkOutput("cmd_sel", 64'(sel), 64'(e.sel));
      checkOutput("cmd_addr", addr, e.addr);
      checkOutput("cmd_bytes", 64'(bytes), 64'(e.bytes));
    end
  endtask

  // Handshake monitor: in-order command check, hold stability, valid
  // exclusivity and the credit bound, sampled mid-cycle.
  logic        prevRdPend = 1'b0, prevWrPend = 1'b0, prevRdSel = 1'b0;
  logic [63:0] prevRdAddr = '0, prevWrAddr = '0;
  logic [31:0] prevRdBytes = '0, prevWrBytes = '0;

  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      prevRdPend = 1'b0;
      prevWrPend = 1'b0;
      modelOut   = 0;
    end else begin
      checkOutput("valid_exclusive", 64'(rd_cmd_valid && wr_cmd_valid), 64'd0);
      if (prevRdPend) begin
        checkOutput("rd_hold_valid", 64'(rd_cmd_valid), 64'd1);
        checkOutput("rd_hold_addr", rd_cmd_addr, prevRdAddr);
        checkOutput("rd_hold_bytes", 64'(rd_cmd_bytes), 64'(prevRdBytes));
        checkOutput("rd_hold_sel", 64'(rd_cmd_sel), 64'(prevRdSel));
      end
      if (prevWrPend) begin
        checkOutput("wr_hold_valid", 64'(wr_cmd_valid), 64'd1);
        checkOutput("wr_hold_addr", wr_cmd_addr, prevWrAddr);
        checkOutput("wr_hold_bytes", 64'(wr_cmd_bytes), 64'(prevWrBytes));
      end
      if (rd_cmd_valid && rd_cmd_ready) begin
        if (!rd_cmd_sel) checkOutput("credit_limit", 64'(modelOut < MAXO), 64'd1);
        compareCmd(1'b0, rd_cmd_sel, rd_cmd_addr, rd_cmd_bytes);
      end
      if (wr_cmd_valid && wr_cmd_ready) begin
        compareCmd(1'b1, 1'b0, wr_cmd_addr, wr_cmd_bytes);
        wrCount++;
        respQ.push_back(cyc + (randResp ? int'($urandom_range(1, 8)) : 5));
      end
      if (wr_resp) lastRespCyc = cyc;
      if ((wr_cmd_valid && wr_cmd_ready) && !wr_resp) modelOut++;
      else if (wr_resp && !(wr_cmd_valid && wr_cmd_ready) && modelOut > 0) modelOut--;
      prevRdPend  = rd_cmd_valid && !rd_cmd_ready;
      prevRdAddr  = rd_cmd_addr;
      prevRdBytes = rd_cmd_bytes;
      prevRdSel   = rd_cmd_sel;
      prevWrPend  = wr_cmd_valid && !wr_cmd_ready;
      prevWrAddr  = wr_cmd_addr;
      prevWrBytes = wr_cmd_bytes;
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
    if (randReady) begin
      rd_cmd_ready = 1'($urandom_range(0, 1));
      wr_cmd_ready = 1'($urandom_range(0, 1));
    end
    wr_resp = 1'b0;
    if (autoResp && respQ.size() > 0) begin
      if (respQ[0] <= cyc) begin
        wr_resp = 1'b1;
        void'(respQ.pop_front());
      end
    end
  endtask

  // Reference model: the job as a flat list of A, B, C commands per chunk.
  task automatic buildExp(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                          input logic [31:0] len);
    logic [31:0] flen, off, n;
    cmd_t e;
    flen = len & ~32'd63;
    off  = 0;
    while (off < flen) begin
      n = (flen - off < 32'(BURST)) ? flen - off : 32'(BURST);
      e.isWr = 1'b0; e.sel = 1'b0; e.addr = a + 64'(off); e.bytes = n; expQ.push_back(e);
      e.sel  = 1'b1; e.addr = b + 64'(off); expQ.push_back(e);
      e.isWr = 1'b1; e.sel = 1'b0; e.addr = c + 64'(off); expQ.push_back(e);
      off += n;
    end
  endtask

  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                               input logic [31:0] len);
    base_a = a; base_b = b; base_c = c; len_bytes = len;
    buildExp(a, b, c, len);
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    checkOutput("idle_low_c1", 64'(ap_idle), 64'd0);
    if ((len & ~32'd63) != 0) checkOutput("rd_valid_c1", 64'(rd_cmd_valid), 64'd1);
  endtask

  task automatic waitDone(input string tag, input int budget, input bit checkDrain);
    int n = 0;
    while (!ap_done && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, "_done_seen"}, 64'(ap_done), 64'd1);
    if (ap_done) begin
      checkOutput({tag, "_ready_with_done"}, 64'(ap_ready), 64'd1);
      checkOutput({tag, "_all_cmds_issued"}, 64'(expQ.size()), 64'd0);
      if (checkDrain) checkOutput({tag, "_done_after_resp"}, 64'(cyc - lastRespCyc), 64'd2);
      tick();
      checkOutput({tag, "_done_one_cycle"}, 64'(ap_done), 64'd0);
      checkOutput({tag, "_idle_after_done"}, 64'(ap_idle), 64'd1);
    end
  endtask

  initial begin
    int n;
    int wrBase;
    logic [31:0] rlen;
    logic [63:0] zlens [2];

    // Reset state
    repeat (3) @(posedge ap_clk);
    #1;
    checkOutput("rst_idle", 64'(ap_idle), 64'd1);
    checkOutput("rst_ready", 64'(ap_ready), 64'd0);
    checkOutput("rst_done", 64'(ap_done), 64'd0);
    checkOutput("rst_rd_valid", 64'(rd_cmd_valid), 64'd0);
    checkOutput("rst_wr_valid", 64'(wr_cmd_valid), 64'd0);
    checkOutput("rst_rd_addr", rd_cmd_addr, 64'd0);
    checkOutput("rst_rd_bytes", 64'(rd_cmd_bytes), 64'd0);
    checkOutput("rst_rd_sel", 64'(rd_cmd_sel), 64'd0);
    checkOutput("rst_wr_addr", wr_cmd_addr, 64'd0);
    checkOutput("rst_wr_bytes", 64'(wr_cmd_bytes), 64'd0);
    ap_rst_n = 1'b1;
    tick();

    // Two full chunks; a mid-job start with different parameters must be ignored
    applyStimulus(64'h1000, 64'h9000, 64'h11000, 32'd8192);
    repeat (2) tick();
    base_a = 64'hDEAD_0000; len_bytes = 32'd640; ap_start = 1'b1;
    repeat (3) tick();
    ap_start = 1'b0;
    waitDone("t8192", 200, 1'b1);

    // Floored tail chunk of 64 bytes
    applyStimulus(64'h5_0000, 64'h6_0000, 64'h7_0000, 32'd4190);
    waitDone("t4190", 200, 1'b1);

    // Zero-length and sub-beat jobs issue nothing
    zlens[0] = 64'd0;
    zlens[1] = 64'd63;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(64'h100, 64'h200, 64'h300, 32'(zlens[i]));
      checkOutput("zero_done_c1", 64'(ap_done), 64'd0);
      checkOutput("zero_rdv_c1", 64'(rd_cmd_valid), 64'd0);
      tick();
      checkOutput("zero_done_c2", 64'(ap_done), 64'd1);
      checkOutput("zero_ready_c2", 64'(ap_ready), 64'd1);
      tick();
      checkOutput("zero_done_c3", 64'(ap_done), 64'd0);
      checkOutput("zero_idle_c3", 64'(ap_idle), 64'd1);
    end

    // Backpressure on the B command for 10 cycles
    rd_cmd_ready = 1'b0;
    applyStimulus(64'h2_0000, 64'h3_0000, 64'h4_0000, 32'd4096);
    rd_cmd_ready = 1'b1;
    tick();
    rd_cmd_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_b_valid", 64'(rd_cmd_valid), 64'd1);
      checkOutput("stall_b_sel", 64'(rd_cmd_sel), 64'd1);
      checkOutput("stall_b_addr", rd_cmd_addr, 64'h3_0000);
      checkOutput("stall_b_bytes", 64'(rd_cmd_bytes), 64'd4096);
      tick();
    end
    rd_cmd_ready = 1'b1;
    tick();
    checkOutput("stall_b_taken", 64'(rd_cmd_valid), 64'd0);
    checkOutput("stall_c_valid", 64'(wr_cmd_valid), 64'd1);
    waitDone("tstall", 200, 1'b1);

    // Responses withheld: credits stop issue after MAX_OUT chunks
    autoResp = 1'b0;
    wrBase = wrCount;
    applyStimulus(64'h10_0000, 64'h20_0000, 64'h30_0000, 32'd32768);
    repeat (40) tick();
    checkOutput("withheld_c_count", 64'(wrCount - wrBase), 64'd4);
    checkOutput("withheld_no_rd", 64'(rd_cmd_valid), 64'd0);
    autoResp = 1'b1;
    waitDone("twithheld", 400, 1'b1);

    // A response coincident with a C handshake frees exactly one more chunk
    autoResp = 1'b0;
    wrBase = wrCount;
    applyStimulus(64'h40_0000, 64'h50_0000, 64'h60_0000, 32'd32768);
    n = 0;
    while (!((wrCount - wrBase == 3) && wr_cmd_valid) && n < 100) begin
      tick();
      n++;
    end
    checkOutput("coinc_reach_c4", 64'(wr_cmd_valid), 64'd1);
    wr_resp = 1'b1;
    if (respQ.size() > 0) void'(respQ.pop_front());
    tick();
    repeat (30) tick();
    checkOutput("coinc_c_count", 64'(wrCount - wrBase), 64'd5);
    checkOutput("coinc_no_rd", 64'(rd_cmd_valid), 64'd0);
    autoResp = 1'b1;
    waitDone("tcoinc", 400, 1'b1);

    // Asynchronous reset while a write command is pending
    applyStimulus(64'h7000, 64'h8000, 64'h9000, 32'd8192);
    n = 0;
    while (!wr_cmd_valid && n < 50) begin
      tick();
      n++;
    end
    checkOutput("arst_reach_c", 64'(wr_cmd_valid), 64'd1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    checkOutput("arst_wr_drop", 64'(wr_cmd_valid), 64'd0);
    checkOutput("arst_rd_drop", 64'(rd_cmd_valid), 64'd0);
    expQ.delete();
    respQ.delete();
    wr_resp = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    checkOutput("arst_no_done", 64'(ap_done), 64'd0);
    ap_rst_n = 1'b1;
    tick();
    checkOutput("arst_idle", 64'(ap_idle), 64'd1);
    applyStimulus(64'hA000, 64'hB000, 64'hC000, 32'd4160);
    waitDone("tpostrst", 200, 1'b1);

    // Randomized handshakes, including an address wrap past 2^64
    randReady = 1'b1;
    randResp = 1'b1;
    applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, 64'hFFFF_FFFF_FFFF_F000, 32'd8192);
    waitDone("twrap", 1000, 1'b1);
    for (int j = 0; j < 4; j++) begin
      rlen = 32'($urandom_range(0, 20000));
      applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, rlen);
      waitDone("trand", 1000, (rlen & ~32'd63) != 0);
    end
    randReady = 1'b0;
    rd_cmd_ready = 1'b1;
    wr_cmd_ready = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
